// File: rtl/soc_result_monitor_if.sv
// soc_result_monitor_if: CPU native memory bus plus trap line, as seen by a snooping monitor
interface soc_result_monitor_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        trap;
    modport master (output mem_valid, mem_ready, mem_addr, mem_wdata, mem_wstrb, trap);
    modport slave  (input  mem_valid, mem_ready, mem_addr, mem_wdata, mem_wstrb, trap);
endinterface

// File: rtl/soc_result_monitor.sv
// soc_result_monitor: snoops result-word writes, compares them and reports a terminal verdict
module soc_result_monitor #(
    parameter int          NUM_CHECKS     = 1,
    parameter logic [31:0] CHECK_BASE     = 32'h0000_0400,
    parameter int          TIMEOUT_CYCLES = 20000,
    parameter int          CNT_W          = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    clear,
    soc_result_monitor_if.slave     bus,
    input  logic [32*NUM_CHECKS-1:0] expected,
    output logic                    done,
    output logic                    pass,
    output logic [1:0]              cause,
    output logic [NUM_CHECKS-1:0]   mismatch,
    output logic [CNT_W-1:0]        cycle_count,
    output logic [32*NUM_CHECKS-1:0] captured
);
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    logic [1:0]              state;
    logic [4*NUM_CHECKS-1:0] lane_seen, seen_n;
    logic [32*NUM_CHECKS-1:0] cap_n;
    logic [NUM_CHECKS-1:0]   mm;
    logic                    beat;
    logic                    unused_addr_lsb;
    assign beat = bus.mem_valid & bus.mem_ready & (|bus.mem_wstrb);
    assign unused_addr_lsb = &{1'b0, bus.mem_addr[1:0]};
    // Next captured bytes and lane flags for this cycle's beat, plus the per-word compare
    always_comb begin
        cap_n  = captured;
        seen_n = lane_seen;
        mm     = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            mm[i] = captured[32*i +: 32] != expected[32*i +: 32];
            for (int k = 0; k < 4; k++)
                if (beat && bus.mem_addr[31:2] == CHECK_BASE[31:2] + 30'(i) && bus.mem_wstrb[k]) begin
                    cap_n[32*i+8*k +: 8] = bus.mem_wdata[8*k +: 8];
                    seen_n[4*i+k]        = 1'b1;
                end
        end
    end
    // Verdict state machine: capture and count in RUN, compare in CHECK, freeze in DONE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_RUN;
            lane_seen   <= '0;
            captured    <= '0;
            mismatch    <= '0;
            cycle_count <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            cause       <= 2'd0;
        end else if (clear) begin
            state       <= S_RUN;
            lane_seen   <= '0;
            captured    <= '0;
            mismatch    <= '0;
            cycle_count <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            cause       <= 2'd0;
        end else if (state == S_RUN) begin
            captured    <= cap_n;
            lane_seen   <= seen_n;
            cycle_count <= cycle_count + 1'b1;
            if (bus.trap) begin
                state <= S_DONE;
                done  <= 1'b1;
                cause <= 2'd2;
            end else if (&seen_n) begin
                state <= S_CHECK;
            end else if (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state <= S_DONE;
                done  <= 1'b1;
                cause <= 2'd3;
            end
        end else if (state == S_CHECK) begin
            state    <= S_DONE;
            mismatch <= mm;
            done     <= 1'b1;
            pass     <= ~|mm;
            cause    <= |mm ? 2'd1 : 2'd0;
        end
    end
endmodule

// File: tb/tb_soc_result_monitor.sv
// tb_soc_result_monitor: scoreboard bench for verdict, capture, timeout, trap, clear and reset
module tb_soc_result_monitor;
    typedef struct {
        logic [1:0]  cause;
        logic        pass;
        logic [1:0]  mm;
        logic [63:0] cap;
    } verdict_t;
    logic clk = 1'b0;
    logic resetn, clear;
    logic [31:0] exp_a;
    logic [63:0] exp_b;
    logic done_a, pass_a, done_b, pass_b;
    logic [1:0] cause_a, cause_b, mm_b;
    logic [0:0] mm_a;
    logic [31:0] cnt_a, cnt_b, cap_a;
    logic [63:0] cap_b;
    int checks = 0;
    int passed = 0;
    verdict_t sb[$];
    soc_result_monitor_if bus();
    soc_result_monitor #(.NUM_CHECKS(1), .CHECK_BASE(32'h400), .TIMEOUT_CYCLES(100)) dut_a (
        .clk(clk), .resetn(resetn), .clear(clear), .bus(bus), .expected(exp_a),
        .done(done_a), .pass(pass_a), .cause(cause_a), .mismatch(mm_a),
        .cycle_count(cnt_a), .captured(cap_a));
    soc_result_monitor #(.NUM_CHECKS(2), .CHECK_BASE(32'h400), .TIMEOUT_CYCLES(20000)) dut_b (
        .clk(clk), .resetn(resetn), .clear(clear), .bus(bus), .expected(exp_b),
        .done(done_b), .pass(pass_b), .cause(cause_b), .mismatch(mm_b),
        .cycle_count(cnt_b), .captured(cap_b));
    always #5 clk = ~clk;
    task automatic idle();
        bus.mem_valid = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        bus.trap      = 1'b0;
    endtask
    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.mem_valid = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_wstrb = s;
        @(negedge clk);
        idle();
    endtask
    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask
    task automatic test_reset();
        checks++; if (done_a !== 1'b0) $display("FAIL reset_done got %0d want 0", done_a); else passed++;
        checks++; if (pass_a !== 1'b0) $display("FAIL reset_pass got %0d want 0", pass_a); else passed++;
        checks++; if (cause_a !== 2'd0) $display("FAIL reset_cause got %0d want 0", cause_a); else passed++;
        checks++; if (cnt_a !== 32'd0) $display("FAIL reset_count got %0d want 0", cnt_a); else passed++;
        checks++; if (cap_a !== 32'd0) $display("FAIL reset_captured got %h want 0", cap_a); else passed++;
        checks++; if (mm_b !== 2'b00) $display("FAIL reset_mismatch got %b want 00", mm_b); else passed++;
    endtask
    task automatic test_pass();
        verdict_t v;
        pulse_clear();
        exp_a = 32'd30;
        sb.push_back('{2'd0, 1'b1, 2'b00, 64'd30});
        write(32'h400, 32'h0000_001E, 4'hF);
        checks++; if (done_a !== 1'b0) $display("FAIL pass_early_done got %0d want 0", done_a); else passed++;
        @(negedge clk);
        checks++; if (done_a !== 1'b1) $display("FAIL pass_latency got %0d want 1", done_a); else passed++;
        v = sb.pop_front();
        checks++; if (cause_a !== v.cause) $display("FAIL pass_cause got %0d want %0d", cause_a, v.cause); else passed++;
        checks++; if (pass_a !== v.pass) $display("FAIL pass_flag got %0d want %0d", pass_a, v.pass); else passed++;
        checks++; if (cap_a !== v.cap[31:0]) $display("FAIL pass_captured got %h want %h", cap_a, v.cap[31:0]); else passed++;
    endtask
    task automatic test_bytewise();
        verdict_t v;
        pulse_clear();
        exp_b = {32'h0000_1234, 32'h0000_0000};
        sb.push_back('{2'd1, 1'b0, 2'b01, {32'h0000_1234, 32'hDEAD_BEEF}});
        write(32'h404, 32'h0000_0034, 4'b0001);
        write(32'h404, 32'h0000_1200, 4'b0010);
        write(32'h404, 32'h0000_0000, 4'b1100);
        checks++; if (done_b !== 1'b0) $display("FAIL bytewise_partial_done got %0d want 0", done_b); else passed++;
        write(32'h400, 32'hDEAD_BEEF, 4'hF);
        for (int n = 0; n < 4 && done_b !== 1'b1; n++) @(negedge clk);
        checks++; if (done_b !== 1'b1) $display("FAIL bytewise_done got %0d want 1", done_b); else passed++;
        v = sb.pop_front();
        checks++; if (cause_b !== v.cause) $display("FAIL bytewise_cause got %0d want %0d", cause_b, v.cause); else passed++;
        checks++; if (pass_b !== v.pass) $display("FAIL bytewise_pass got %0d want %0d", pass_b, v.pass); else passed++;
        checks++; if (mm_b !== v.mm) $display("FAIL bytewise_mismatch got %b want %b", mm_b, v.mm); else passed++;
        checks++; if (cap_b !== v.cap) $display("FAIL bytewise_captured got %h want %h", cap_b, v.cap); else passed++;
    endtask
    task automatic test_stall();
        verdict_t v;
        pulse_clear();
        exp_a = 32'h0000_CAFE;
        sb.push_back('{2'd0, 1'b1, 2'b00, 64'h0000_CAFE});
        bus.mem_valid = 1'b1;
        bus.mem_ready = 1'b0;
        bus.mem_addr  = 32'h400;
        bus.mem_wdata = 32'h0000_CAFE;
        bus.mem_wstrb = 4'hF;
        repeat (5) @(negedge clk);
        checks++; if (cap_a !== 32'd0) $display("FAIL stall_no_capture got %h want 0", cap_a); else passed++;
        checks++; if (done_a !== 1'b0) $display("FAIL stall_done got %0d want 0", done_a); else passed++;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        idle();
        checks++; if (cap_a !== 32'h0000_CAFE) $display("FAIL stall_capture got %h want 0000cafe", cap_a); else passed++;
        checks++; if (done_a !== 1'b0) $display("FAIL stall_early_done got %0d want 0", done_a); else passed++;
        @(negedge clk);
        checks++; if (done_a !== 1'b1) $display("FAIL stall_latency got %0d want 1", done_a); else passed++;
        v = sb.pop_front();
        checks++; if (cause_a !== v.cause) $display("FAIL stall_cause got %0d want %0d", cause_a, v.cause); else passed++;
        checks++; if (pass_a !== v.pass) $display("FAIL stall_pass got %0d want %0d", pass_a, v.pass); else passed++;
    endtask
    task automatic test_timeout();
        verdict_t v;
        pulse_clear();
        exp_a = 32'd0;
        sb.push_back('{2'd3, 1'b0, 2'b00, 64'd0});
        repeat (99) @(negedge clk);
        checks++; if (done_a !== 1'b0) $display("FAIL timeout_early got %0d want 0", done_a); else passed++;
        checks++; if (cnt_a !== 32'd99) $display("FAIL timeout_count99 got %0d want 99", cnt_a); else passed++;
        @(negedge clk);
        checks++; if (done_a !== 1'b1) $display("FAIL timeout_done got %0d want 1", done_a); else passed++;
        v = sb.pop_front();
        checks++; if (cause_a !== v.cause) $display("FAIL timeout_cause got %0d want %0d", cause_a, v.cause); else passed++;
        checks++; if (cnt_a !== 32'd100) $display("FAIL timeout_count got %0d want 100", cnt_a); else passed++;
        write(32'h400, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        checks++; if (cap_a !== v.cap[31:0]) $display("FAIL timeout_frozen_capture got %h want %h", cap_a, v.cap[31:0]); else passed++;
        checks++; if (cnt_a !== 32'd100) $display("FAIL timeout_frozen_count got %0d want 100", cnt_a); else passed++;
    endtask
    task automatic test_trap_clear();
        verdict_t v;
        pulse_clear();
        exp_a = 32'h0000_0055;
        sb.push_back('{2'd2, 1'b0, 2'b00, 64'h1234_5678});
        bus.trap = 1'b1;
        write(32'h400, 32'h1234_5678, 4'hF);
        checks++; if (done_a !== 1'b1) $display("FAIL trap_done got %0d want 1", done_a); else passed++;
        v = sb.pop_front();
        checks++; if (cause_a !== v.cause) $display("FAIL trap_cause got %0d want %0d", cause_a, v.cause); else passed++;
        checks++; if (cap_a !== v.cap[31:0]) $display("FAIL trap_captured got %h want %h", cap_a, v.cap[31:0]); else passed++;
        pulse_clear();
        checks++; if (done_a !== 1'b0) $display("FAIL clear_done got %0d want 0", done_a); else passed++;
        checks++; if (cnt_a !== 32'd0) $display("FAIL clear_count got %0d want 0", cnt_a); else passed++;
        checks++; if (cap_a !== 32'd0) $display("FAIL clear_captured got %h want 0", cap_a); else passed++;
        sb.push_back('{2'd0, 1'b1, 2'b00, 64'h55});
        write(32'h400, 32'h0000_0055, 4'hF);
        for (int n = 0; n < 4 && done_a !== 1'b1; n++) @(negedge clk);
        v = sb.pop_front();
        checks++; if (done_a !== 1'b1) $display("FAIL clear_rerun_done got %0d want 1", done_a); else passed++;
        checks++; if (cause_a !== v.cause) $display("FAIL clear_rerun_cause got %0d want %0d", cause_a, v.cause); else passed++;
        checks++; if (pass_a !== v.pass) $display("FAIL clear_rerun_pass got %0d want %0d", pass_a, v.pass); else passed++;
    endtask
    task automatic test_reset_in_check();
        pulse_clear();
        exp_a = 32'd30;
        write(32'h400, 32'h0000_001E, 4'hF);
        resetn = 1'b0;
        #1;
        checks++; if (cap_a !== 32'd0) $display("FAIL rst_check_captured got %h want 0", cap_a); else passed++;
        checks++; if (cnt_a !== 32'd0) $display("FAIL rst_check_count got %0d want 0", cnt_a); else passed++;
        checks++; if (done_a !== 1'b0) $display("FAIL rst_check_done got %0d want 0", done_a); else passed++;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (cnt_a !== 32'd1) $display("FAIL rst_release_count1 got %0d want 1", cnt_a); else passed++;
        @(negedge clk);
        checks++; if (cnt_a !== 32'd2) $display("FAIL rst_release_count2 got %0d want 2", cnt_a); else passed++;
        checks++; if (done_a !== 1'b0) $display("FAIL rst_release_done got %0d want 0", done_a); else passed++;
    endtask
    initial begin
        resetn = 1'b0;
        clear  = 1'b0;
        exp_a  = '0;
        exp_b  = '0;
        idle();
        repeat (2) @(negedge clk);
        test_reset();
        resetn = 1'b1;
        test_pass();
        test_bytewise();
        test_stall();
        test_timeout();
        test_trap_clear();
        test_reset_in_check();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
